ising_sweep_sched: RTL and testbench

Sweep scheduler for the Metropolis spin-update datapath. It sequences a ROWS×COLS toroidal lattice one row per cycle in checkerboard order: the even sublattice first, then the odd. For each issued row it drives the read addresses (row, up, down), the parity phase and the update enable. It returns a write-back strobe after the datapath latency. Between phases it drains, so no spin unit reads a neighbour whose update is still in flight.

---
 rtl/ising_sweep_sched.sv | 170 +++++++++++++++++
 tb/tb_ising_sweep_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ising_sweep_sched.sv
// Checkerboard sweep scheduler for the Metropolis spin-update datapath.
// Optional flip statistics are built when ISING_SCHED_STATS_EN is defined.
module ising_sweep_sched #(
  parameter int ROWS = 16,
  parameter int LAT  = 2,
  parameter int SW_W = 16,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [SW_W-1:0] num_sweeps,
`ifdef ISING_SCHED_STATS_EN
  input  logic [15:0]     flip_cnt,
  output logic [31:0]     total_flips,
`endif
  output logic            busy,
  output logic            done,
  output logic            upd_en,
  output logic [RW-1:0]   row_addr,
  output logic [RW-1:0]   row_up,
  output logic [RW-1:0]   row_dn,
  output logic            phase,
  output logic            wb_en,
  output logic [RW-1:0]   wb_row,
  output logic            wb_phase,
  output logic [SW_W-1:0] sweep_count
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          en;
    logic [RW-1:0] row;
    logic          ph;
  } wb_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic            phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW_W-1:0] sc_q, sc_d, sc_inc;
  logic [SW_W-1:0] nsw_q, nsw_d;
  logic            abt_q, abt_d;

  wb_t             wb_in;
  wb_t [LAT:1]     wb_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      sc_q    <= '0;
      nsw_q   <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      nsw_q   <= nsw_d;
      abt_q   <= abt_d;
    end
  end

  assign sc_inc = sc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    nsw_d   = nsw_q;
    abt_d   = abt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nsw_d   = num_sweeps;
          sc_d    = '0;
          phase_d = 1'b0;
          row_d   = '0;
          abt_d   = 1'b0;
          state_d = (num_sweeps == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          abt_d   = 1'b1;
          cnt_d   = CW'(LAT - 1);
          state_d = DRAIN;
        end else if (row_q == RW'(ROWS - 1)) begin
          cnt_d   = CW'(LAT - 1);
          state_d = DRAIN;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      DRAIN: begin
        abt_d = abt_q | abort;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (abt_q || abort) begin
          state_d = DONE;
        end else if (!phase_q) begin
          phase_d = 1'b1;
          row_d   = '0;
          state_d = ISSUE;
        end else begin
          // a full sweep is only credited once its odd phase has drained
          sc_d = sc_inc;
          if (sc_inc < nsw_q) begin
            phase_d = 1'b0;
            row_d   = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // abort suppresses the row addressed in the same cycle
  assign upd_en      = (state_q == ISSUE) && !abort;
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign row_addr    = row_q;
  assign phase       = phase_q;
  assign sweep_count = sc_q;

  // neighbours read as zero outside a run so reset leaves every output at 0
  assign row_up = !busy ? '0 : (row_q == '0) ? RW'(ROWS - 1) : row_q - 1'b1;
  assign row_dn = !busy ? '0 : (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;

  assign wb_in = '{en: upd_en, row: row_q, ph: phase_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_pipe <= '0;
    end else begin
      wb_pipe[1] <= wb_in;
      for (int i = 2; i <= LAT; i++) wb_pipe[i] <= wb_pipe[i-1];
    end
  end

  assign wb_en    = wb_pipe[LAT].en;
  assign wb_row   = wb_pipe[LAT].row;
  assign wb_phase = wb_pipe[LAT].ph;

`ifdef ISING_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      total_flips <= '0;
    else if (state_q == IDLE && start)
      total_flips <= '0;
    else if (wb_pipe[LAT].en)
      total_flips <= total_flips + 32'(flip_cnt);
  end
`endif

endmodule

// File: tb/tb_ising_sweep_sched.sv
// Directed plus randomized bench for ising_sweep_sched against a
// cycle-schedule model derived from the sweep timing rules.
module tb_ising_sweep_sched;
  localparam int ROWS = 16;
  localparam int LAT  = 2;
  localparam int SW_W = 16;
  localparam int RW   = $clog2(ROWS);
  localparam int PER  = ROWS + LAT;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [SW_W-1:0] num_sweeps;
  logic            busy, done, upd_en, phase, wb_en, wb_phase;
  logic [RW-1:0]   row_addr, row_up, row_dn, wb_row;
  logic [SW_W-1:0] sweep_count;
`ifdef ISING_SCHED_STATS_EN
  logic [15:0]     flip_cnt;
  logic [31:0]     total_flips;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int cur_k = 0;
  int m_n, m_ka;

  always #5 clk = ~clk;

  ising_sweep_sched #(.ROWS(ROWS), .LAT(LAT), .SW_W(SW_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_sweeps(num_sweeps),
`ifdef ISING_SCHED_STATS_EN
    .flip_cnt(flip_cnt), .total_flips(total_flips),
`endif
    .busy(busy), .done(done), .upd_en(upd_en), .row_addr(row_addr),
    .row_up(row_up), .row_dn(row_dn), .phase(phase), .wb_en(wb_en),
    .wb_row(wb_row), .wb_phase(wb_phase), .sweep_count(sweep_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
  endtask

  // cycle k counts from the accepted start edge (k=1 is the first busy cycle)
  function automatic bit m_upd(input int k);
    if (k < 1 || k > 2 * m_n * PER) return 1'b0;
    if (m_ka > 0 && k >= m_ka) return 1'b0;
    return ((k - 1) % PER) < ROWS;
  endfunction

  function automatic int m_row(input int k);
    return (k - 1) % PER;
  endfunction

  function automatic int m_ph(input int k);
    return ((k - 1) / PER) % 2;
  endfunction

  function automatic int m_done_k();
    if (m_ka < 0) return 2 * m_n * PER + 1;
    if (((m_ka - 1) % PER) < ROWS) return m_ka + LAT + 1;
    return ((m_ka - 1) / PER + 1) * PER + 1;
  endfunction

  function automatic int m_sweeps();
    if (m_ka < 0) return m_n;
    return ((m_ka - 1) / PER) / 2;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".upd_en"}, upd_en, 0);
    chk({tag, ".wb_en"}, wb_en, 0);
    chk({tag, ".phase"}, phase, 0);
    chk({tag, ".wb_phase"}, wb_phase, 0);
    chk({tag, ".row_addr"}, row_addr, 0);
    chk({tag, ".row_up"}, row_up, 0);
    chk({tag, ".row_dn"}, row_dn, 0);
    chk({tag, ".wb_row"}, wb_row, 0);
    chk({tag, ".sweep_count"}, sweep_count, 0);
`ifdef ISING_SCHED_STATS_EN
    chk({tag, ".total_flips"}, total_flips, 0);
`endif
  endtask

  task automatic run(input int n, input int ka, input bit rnd_start);
    int dk;
    longint flips_exp;
    m_n = n;
    m_ka = ka;
    dk = m_done_k();
    flips_exp = 0;
    @(negedge clk);
    cur_k = 0;
    num_sweeps = SW_W'(n);
    start = 1'b1;
    abort = 1'b0;
    for (int k = 1; k <= dk + 2; k++) begin
      @(negedge clk);
      cur_k = k;
      start = (rnd_start && k <= dk) ? 1'($urandom_range(0, 1)) : 1'b0;
      num_sweeps = SW_W'($urandom_range(0, 7));
      abort = (k == ka);
`ifdef ISING_SCHED_STATS_EN
      flip_cnt = 16'($urandom_range(0, 64));
`endif
      #1;
      chk("busy", busy, (k < dk));
      chk("done", done, (k == dk));
      chk("upd_en", upd_en, m_upd(k));
      if (m_upd(k)) begin
        chk("row_addr", row_addr, m_row(k));
        chk("phase", phase, m_ph(k));
        chk("row_up", row_up, (m_row(k) + ROWS - 1) % ROWS);
        chk("row_dn", row_dn, (m_row(k) + 1) % ROWS);
      end
      chk("wb_en", wb_en, m_upd(k - LAT));
      if (m_upd(k - LAT)) begin
        chk("wb_row", wb_row, m_row(k - LAT));
        chk("wb_phase", wb_phase, m_ph(k - LAT));
`ifdef ISING_SCHED_STATS_EN
        flips_exp += flip_cnt;
`endif
      end
      if (k >= dk) chk("sweep_count", sweep_count, m_sweeps());
`ifdef ISING_SCHED_STATS_EN
      if (k == 1) chk("total_flips_clr", total_flips, 0);
      if (k == dk + 2) chk("total_flips", total_flips, 32'(flips_exp));
`endif
    end
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_sweeps = '0;
`ifdef ISING_SCHED_STATS_EN
    flip_cnt = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // one sweep, fixed 37-cycle run; then zero sweeps; then abort in sweep 2 phase 1 row 7
    run(1, -1, 1'b0);
    run(0, -1, 1'b1);
    run(3, 1 + 3 * PER + 7, 1'b0);

    // asynchronous reset while issuing row 5 discards the in-flight rows
    @(negedge clk);
    num_sweeps = SW_W'(2);
    start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cur_k = k;
      start = 1'b0;
    end
    #1;
    chk("pre_rst.row_addr", row_addr, 5);
    #1;
    reset = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst.wb_en", wb_en, 0);
      chk("post_rst.busy", busy, 0);
      chk("post_rst.upd_en", upd_en, 0);
    end

    run(2, -1, 1'b1);
    for (int it = 0; it < 6; it++) begin
      int n, ka;
      n = $urandom_range(1, 3);
      ka = -1;
      if ($urandom_range(0, 1) == 1)
        ka = 1 + $urandom_range(0, 2 * n - 1) * PER + $urandom_range(0, PER - 1);
      run(n, ka, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
